// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 permutation tables,
// the 16-entry per-round left-shift schedule and the FSM state type.
// Table entries use DES numbering: bit 1 is the MSB of the source vector.
package des_pkg;

  // FSM state type; kept as plain constants so older tools see simple vectors
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_GEN  = 1'b1;

  // PC-1: 64-bit key -> 56-bit C||D (parity bits 8,16,..,64 dropped)
  localparam logic [6:0] PC1_TAB [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 56-bit C||D -> 48-bit round subkey
  localparam logic [5:0] PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied to reach round i+1 (index 0 = round 1)
  localparam logic [1:0] SHIFT_SCHED [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Rotation needed to reach output position pos (0-based).
  // Encrypt walks the schedule forward with left rotates. Decrypt starts at
  // C16/D16 (== C0/D0, the schedule sums to 28) and undoes round 17-j with a
  // right rotate, which is the forward table read back-to-front.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] pos);
    logic [3:0] mirror;
    mirror = 4'd0 - pos;
    if (!dec)
      shift_amt = SHIFT_SCHED[pos];
    else if (pos == 4'd0)
      shift_amt = 2'd0;
    else
      shift_amt = SHIFT_SCHED[mirror];
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit C||D in, 48-bit round subkey out.
// Purely combinational.
module des_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd,
  output logic [1:48] subkey
);

  // Eight C||D bits are discarded by PC-2 by design
  logic unused_dropped;
  assign unused_dropped = ^{cd[9], cd[18], cd[22], cd[25],
                            cd[35], cd[38], cd[43], cd[54]};

  // Table-driven bit gather
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[i+1] = cd[PC2_TAB[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule generator. Accepts a 64-bit key, then streams the 16
// round subkeys (K1..K16 for encrypt, K16..K1 for decrypt), one per
// handshake. OUT_REG=1 registers oSubkey without adding latency.
// Optional build macro: DES_KEY_SCHED_PARITY_EN enables odd-parity checking
// of every key byte; a bad key pulses oParityErr and is not expanded.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:64] iKey,
  input  logic        iDecrypt,
  input  logic        iKeyValid,
  output logic        oKeyReady,
  output logic [1:48] oSubkey,
  output logic        oSubkeyValid,
  input  logic        iSubkeyReady,
  output logic [3:0]  oRound,
  output logic        oLast,
  output logic        oParityErr
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high. Valid never depends on ready; while valid is high and
  // ready is low the offered data and its sideband (oRound/oLast) hold.

  state_t      state_q;
  logic [1:28] c_q, d_q, c_nxt, d_nxt;
  logic [1:28] base_c, base_d;
  logic [1:56] pc1_key, pc2_in;
  logic [1:48] pc2_out;
  logic [3:0]  round_q, step_pos;
  logic [1:0]  amt;
  logic        dec_q, step_dec, step_en;
  logic        accept, start, hs, key_bad, par_err_q;

  function automatic logic [1:28] rot_left(input logic [1:28] x, input logic [1:0] n);
    case (n)
      2'd1:    rot_left = {x[2:28], x[1]};
      2'd2:    rot_left = {x[3:28], x[1:2]};
      default: rot_left = x;
    endcase
  endfunction

  function automatic logic [1:28] rot_right(input logic [1:28] x, input logic [1:0] n);
    case (n)
      2'd1:    rot_right = {x[28], x[1:27]};
      2'd2:    rot_right = {x[27:28], x[1:26]};
      default: rot_right = x;
    endcase
  endfunction

  assign oKeyReady    = (state_q == ST_IDLE);
  assign oSubkeyValid = (state_q == ST_GEN);
  assign oRound       = round_q;
  assign oLast        = oSubkeyValid & (round_q == 4'd15);
  assign oParityErr   = par_err_q;
  assign accept       = iKeyValid & oKeyReady;
  assign start        = accept & ~key_bad;
  assign hs           = oSubkeyValid & iSubkeyReady;

  // Parity bits are only consumed by the optional checker
  logic unused_parity;
  assign unused_parity = ^{iKey[8], iKey[16], iKey[24], iKey[32],
                           iKey[40], iKey[48], iKey[56], iKey[64]};

`ifdef DES_KEY_SCHED_PARITY_EN
  // Flag any key byte with even parity
  always_comb begin
    key_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (^iKey[8*b+1 +: 8] == 1'b0) key_bad = 1'b1;
    end
  end
`else
  assign key_bad = 1'b0;
`endif

  // PC-1 gather of the offered key
  always_comb begin
    pc1_key = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_key[i+1] = iKey[PC1_TAB[i]];
    end
  end

  // Next C/D: load+first rotate on accept, one schedule step per handshake
  always_comb begin
    base_c   = c_q;
    base_d   = d_q;
    step_dec = dec_q;
    step_pos = round_q + 4'd1;
    step_en  = hs & ~oLast;
    if (state_q == ST_IDLE) begin
      base_c   = pc1_key[1:28];
      base_d   = pc1_key[29:56];
      step_dec = iDecrypt;
      step_pos = 4'd0;
      step_en  = start;
    end
    amt   = shift_amt(step_dec, step_pos);
    c_nxt = c_q;
    d_nxt = d_q;
    if (step_en) begin
      if (step_dec) begin
        c_nxt = rot_right(base_c, amt);
        d_nxt = rot_right(base_d, amt);
      end else begin
        c_nxt = rot_left(base_c, amt);
        d_nxt = rot_left(base_d, amt);
      end
    end
  end

  // FSM, round counter, direction latch, C/D state and parity pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      c_q       <= '0;
      d_q       <= '0;
      round_q   <= 4'd0;
      dec_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= accept & key_bad;
      c_q       <= c_nxt;
      d_q       <= d_nxt;
      if (state_q == ST_IDLE) begin
        if (start) begin
          state_q <= ST_GEN;
          round_q <= 4'd0;
          dec_q   <= iDecrypt;
        end
      end else if (hs) begin
        if (round_q == 4'd15) begin
          state_q <= ST_IDLE;
          round_q <= 4'd0;
        end else begin
          round_q <= round_q + 4'd1;
        end
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     (pc2_in),
    .subkey (pc2_out)
  );

  // Registered mode compresses next-state C/D so the flop lines up with the
  // state it describes; combinational mode compresses the current C/D.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [1:48] subkey_q;
      assign pc2_in  = {c_nxt, d_nxt};
      assign oSubkey = subkey_q;
      // Output subkey register
      always_ff @(posedge clk) begin
        if (rst) subkey_q <= '0;
        else     subkey_q <= pc2_out;
      end
    end else begin : g_out_comb
      assign pc2_in  = {c_q, d_q};
      assign oSubkey = pc2_out;
    end
  endgenerate

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL provide parameter OUT_REG, default 1, meaning 1 = oSubkey registered and first subkey valid one cycle after key accept, 0 = oSubkey driven combinationally from C/D registers and valid in the same cycle state enters GEN.
REQ-002 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port iKey  input  [1:64]  DES key, bit 1 = MSB; bits 8,16,..,64 are parity.
REQ-005 SHALL provide port iDecrypt  input  1  sampled at key accept: 0 = emit K1..K16, 1 = emit K16..K1.
REQ-006 SHALL provide port iKeyValid  input  1  key offer.
REQ-007 SHALL provide port oKeyReady  output  1  key acceptance possible.
REQ-008 SHALL provide port oSubkey  output  [1:48]  round subkey, bit 1 = MSB, for XOR before S-box stage.
REQ-009 SHALL provide port oSubkeyValid  output  1  oSubkey valid.
REQ-010 SHALL provide port iSubkeyReady  input  1  consumer accepts subkey.
REQ-011 SHALL provide port oRound  output  [3:0]  index 0..15 of current output position.
REQ-012 SHALL provide port oLast  output  1  high with oSubkeyValid on 16th subkey.
REQ-013 SHALL provide port oParityErr  output  1  one-cycle pulse on bad-parity key.

Function
REQ-014 SHALL implement FSM states IDLE and GEN only.
REQ-015 SHALL drive oKeyReady=1 only in IDLE; key accept = iKeyValid & oKeyReady.
REQ-016 On accept SHALL load C0/D0 = PC-1(iKey), latch iDecrypt, clear round counter, enter GEN.
REQ-017 Encrypt: output position i (1..16) SHALL be K_i = PC-2(C_i,D_i), C_i/D_i = left-rotate of C_{i-1}/D_{i-1} by 1 for i in {1,2,9,16}, else 2.
REQ-018 Decrypt: position j (1..16) SHALL be K_{17-j}; position 1 = PC-2(C0,D0); later positions right-rotate by schedule 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 In GEN, oSubkeyValid SHALL be 1; C/D, counter, oSubkey SHALL hold while iSubkeyReady=0.
REQ-020 Each handshake (oSubkeyValid & iSubkeyReady) SHALL advance exactly one position; one subkey per cycle when iSubkeyReady held high.
REQ-021 oLast SHALL equal (oRound==15) & oSubkeyValid; handshake with oLast SHALL return to IDLE next cycle.
REQ-022 A new key SHALL NOT be accepted in GEN; earliest next accept is the first IDLE cycle after last handshake.
REQ-023 iKey and iDecrypt changes outside the accept cycle SHALL have no effect.

Reset
REQ-024 rst SHALL force IDLE, oSubkeyValid=0, oLast=0, oParityErr=0, oRound=0, oSubkey=0, oKeyReady=1 on next edge.
REQ-025 rst asserted mid-sequence SHALL discard remaining subkeys with no further handshake; rst has priority over key accept.

Configuration
REQ-026 With DES_KEY_SCHED_PARITY_EN defined, each iKey byte SHALL be checked for odd parity at accept; any failing byte SHALL pulse oParityErr one cycle after accept and the block SHALL remain in IDLE, emitting no subkeys.
REQ-027 Without DES_KEY_SCHED_PARITY_EN, parity bits SHALL be ignored and oParityErr tied 0; port list unchanged.

Structure
REQ-028 Package des_pkg SHALL hold PC-1 and PC-2 tables, 16-entry shift schedule, and the FSM state type.
REQ-029 PC-2 SHALL be a separate combinational sub-module des_pc2 (56 in, 48 out); PC-1 and rotation stay inline.

Verification
REQ-030 Key 133457799BBCDFF1, iDecrypt=0, iSubkeyReady=1 -> first subkey 1B02EFFC7072 at oRound=0, last CB3D8B0E17F5 with oLast=1, 16 consecutive valid cycles.
REQ-031 Same key, iDecrypt=1 -> first subkey CB3D8B0E17F5, 16th 1B02EFFC7072, sequence is exact reverse of REQ-030.
REQ-032 iSubkeyReady toggled randomly -> identical 16-value sequence, oSubkey stable during every stall.
REQ-033 rst pulsed after 5th handshake -> next cycle oSubkeyValid=0, oKeyReady=1; new key restarts at oRound=0.
REQ-034 Parity macro on, key 133457799BBCDFF0 -> oParityErr=1 for one cycle, oSubkeyValid stays 0; macro off -> normal 16 subkeys.
REQ-035 iKeyValid held high across sequence end -> second key accepted only in IDLE, no overlap, oRound restarts at 0.
